soc_timer_tick_sched: RTL

SOC_TIMER_TICK_SCHED -- requirements
Module: soc_timer_tick_sched

---
 rtl/soc_timer_tick_sched_pkg.sv | 43 ++++
 rtl/soc_tick_rr_pick.sv | 28 ++
 rtl/soc_timer_tick_sched.sv | 101 ++++++++++
 3 files changed

// File: rtl/soc_timer_tick_sched_pkg.sv
// Shared types for the timer tick scheduler: FSM states, timer slave register map
// and the per-state bus strobe encoding.
package soc_timer_tick_sched_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT_RELOAD,
    ST_INIT_CTRL,
    ST_WAIT_IRQ,
    ST_ACK,
    ST_READ,
    ST_CHECK,
    ST_DISPATCH,
    ST_STOP
  } state_t;

  localparam logic [2:0] REG_STATUS   = 3'd0;
  localparam logic [2:0] REG_CONTROL  = 3'd1;
  localparam logic [2:0] REG_PERIOD_L = 3'd2;

  typedef struct packed {
    logic        cs;
    logic        write_n;
    logic [2:0]  addr;
    logic [15:0] wdata;
  } bus_t;

  // Bus drive for the cycle spent in a given state; registered from the next state.
  function automatic bus_t bus_for(state_t s);
    bus_t b;
    b = '{cs: 1'b0, write_n: 1'b1, addr: REG_STATUS, wdata: 16'h0000};
    case (s)
      ST_INIT_RELOAD: b = '{cs: 1'b1, write_n: 1'b0, addr: REG_PERIOD_L, wdata: 16'h0000};
      ST_INIT_CTRL:   b = '{cs: 1'b1, write_n: 1'b0, addr: REG_CONTROL,  wdata: 16'h0001};
      ST_ACK:         b = '{cs: 1'b1, write_n: 1'b0, addr: REG_STATUS,   wdata: 16'h0000};
      ST_READ:        b = '{cs: 1'b1, write_n: 1'b1, addr: REG_STATUS,   wdata: 16'h0000};
      ST_STOP:        b = '{cs: 1'b1, write_n: 1'b0, addr: REG_CONTROL,  wdata: 16'h0000};
      default:        b = '{cs: 1'b0, write_n: 1'b1, addr: REG_STATUS,   wdata: 16'h0000};
    endcase
    return b;
  endfunction

endpackage

// File: rtl/soc_tick_rr_pick.sv
// Round-robin search: first set bit of mask strictly after index last, wrapping,
// with last itself searched last.
module soc_tick_rr_pick #(
  parameter int NUM_SLOTS = 4,
  localparam int IW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic [NUM_SLOTS-1:0] mask,
  input  logic [IW-1:0]        last,
  output logic [IW-1:0]        index,
  output logic                 valid
);

  int cand;

  always_comb begin
    index = '0;
    valid = 1'b0;
    cand  = 0;
    for (int k = 1; k <= NUM_SLOTS; k++) begin
      cand = (int'(last) + k) % NUM_SLOTS;
      if (!valid && mask[cand[IW-1:0]]) begin
        index = cand[IW-1:0];
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/soc_timer_tick_sched.sv
// Services an interval timer's interrupt (ack, status re-check) and dispatches one
// round-robin tick per serviced interrupt to the enabled slots.
module soc_timer_tick_sched #(
  parameter int NUM_SLOTS = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [NUM_SLOTS-1:0] slot_en,
  input  logic                 timer_irq,
  output logic [2:0]           m_address,
  output logic                 m_chipselect,
  output logic                 m_write_n,
  output logic [15:0]          m_writedata,
  input  logic [15:0]          m_readdata,
  output logic [NUM_SLOTS-1:0] slot_tick,
  output logic [31:0]          tick_count,
  output logic [7:0]           overrun_count,
  output logic                 busy
);

  import soc_timer_tick_sched_pkg::*;

  localparam int IW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [IW-1:0] LAST_INIT = IW'(NUM_SLOTS - 1);

  state_t        state;
  state_t        next_state;
  bus_t          bus;
  logic [IW-1:0] last_idx;
  logic [IW-1:0] pick_idx;
  logic          pick_valid;
  logic          unused_readdata;

  assign unused_readdata = ^m_readdata[15:1];

  assign m_chipselect = bus.cs;
  assign m_write_n    = bus.write_n;
  assign m_address    = bus.addr;
  assign m_writedata  = bus.wdata;

  soc_tick_rr_pick #(.NUM_SLOTS(NUM_SLOTS)) u_pick (
    .mask  (slot_en),
    .last  (last_idx),
    .index (pick_idx),
    .valid (pick_valid)
  );

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:        if (enable) next_state = ST_INIT_RELOAD;
      ST_INIT_RELOAD: next_state = ST_INIT_CTRL;
      ST_INIT_CTRL:   next_state = ST_WAIT_IRQ;
      ST_WAIT_IRQ: begin
        if (timer_irq)    next_state = ST_ACK;
        else if (!enable) next_state = ST_STOP;
      end
      ST_ACK:         next_state = ST_READ;
      ST_READ:        next_state = ST_CHECK;
      ST_CHECK:       next_state = m_readdata[0] ? ST_ACK : ST_DISPATCH;
      ST_DISPATCH:    next_state = enable ? ST_WAIT_IRQ : ST_STOP;
      ST_STOP:        next_state = ST_IDLE;
      default:        next_state = ST_IDLE;
    endcase
  end

  // Outputs are registered from next_state so they line up with the state's own cycle;
  // the tick and its count are therefore committed on the CHECK -> DISPATCH edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      bus           <= bus_for(ST_IDLE);
      busy          <= 1'b0;
      slot_tick     <= '0;
      tick_count    <= '0;
      overrun_count <= '0;
      last_idx      <= LAST_INIT;
    end else begin
      state     <= next_state;
      bus       <= bus_for(next_state);
      busy      <= (next_state != ST_IDLE);
      slot_tick <= '0;
      if (state == ST_IDLE && next_state == ST_INIT_RELOAD)
        last_idx <= LAST_INIT;
      if (state == ST_CHECK) begin
        if (m_readdata[0]) begin
          if (overrun_count != 8'hFF)
            overrun_count <= overrun_count + 8'd1;
        end else begin
          tick_count <= tick_count + 32'd1;
          if (pick_valid) begin
            slot_tick <= NUM_SLOTS'(1) << pick_idx;
            last_idx  <= pick_idx;
          end
        end
      end
    end
  end

endmodule
